// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
package fetch_pkg;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_DRAIN, S_HALT} state_e;
  localparam logic [4:0]  OPC_HALT = 5'b00000;
  localparam logic [15:0] NOP_INST = 16'h0800;
  localparam int          PC_INCR  = 2;
endpackage

// File: rtl/fetch_out_reg.sv
// fetch_out_reg: decode-facing output register with load, hold and clear.
module fetch_out_reg
  import fetch_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [PC_W-1:0]   pc_plus2_o,
  output logic [INST_W-1:0] inst_o
);
  logic              valid_q;
  logic [PC_W-1:0]   pc_q, pc_plus2_q;
  logic [INST_W-1:0] inst_q;
  // clear only drops valid; payload holds so a stale value never reappears as new data
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      pc_plus2_q <= '0;
      inst_q     <= INST_W'(NOP_INST);
    end else if (load_i) begin
      valid_q    <= 1'b1;
      pc_q       <= pc_i;
      pc_plus2_q <= pc_i + PC_W'(PC_INCR);
      inst_q     <= inst_i;
    end else if (clear_i) begin
      valid_q    <= 1'b0;
    end
  end
  assign valid_o    = valid_q;
  assign pc_o       = pc_q;
  assign pc_plus2_o = pc_plus2_q;
  assign inst_o     = inst_q;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem handshake, redirect squash, halt detect.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/stall performance counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INST_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_rdy,
  input  logic              imem_done,
  input  logic [INST_W-1:0] imem_data,
  input  logic              id_stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              if_valid,
  output logic [PC_W-1:0]   if_pc,
  output logic [PC_W-1:0]   if_pc_plus2,
  output logic [INST_W-1:0] if_inst,
`ifdef FETCH_PERF_CNT_EN
  output logic              fetch_halted,
  output logic [31:0]       perf_fetch_cnt,
  output logic [31:0]       perf_stall_cnt
`else
  output logic              fetch_halted
`endif
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            load, clear;
  always_comb begin
    imem_req = state_q == S_REQ && !redirect && !(if_valid && id_stall);
    load     = state_q == S_WAIT && imem_done && !redirect;
    clear    = redirect || (if_valid && !id_stall);
    pc_d     = redirect ? (redirect_pc & ~PC_W'(1)) : load ? pc_q + PC_W'(PC_INCR) : pc_q;
    state_d  = state_q;
    case (state_q)
      S_REQ:   state_d = imem_req && imem_rdy ? S_WAIT : S_REQ;
      S_WAIT:  state_d = !imem_done ? (redirect ? S_DRAIN : S_WAIT)
                       : redirect ? S_REQ
                       : imem_data[INST_W-1 -: 5] == OPC_HALT ? S_HALT : S_REQ;
      S_DRAIN: state_d = imem_done ? S_REQ : S_DRAIN;
      S_HALT:  state_d = redirect ? S_REQ : S_HALT;
      default: state_d = S_REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end
  assign imem_addr    = pc_q;
  assign fetch_halted = state_q == S_HALT;
  fetch_out_reg #(.PC_W(PC_W), .INST_W(INST_W)) u_out (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .clear_i    (clear),
    .pc_i       (pc_q),
    .inst_i     (imem_data),
    .valid_o    (if_valid),
    .pc_o       (if_pc),
    .pc_plus2_o (if_pc_plus2),
    .inst_o     (if_inst)
  );
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, stall_cnt_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= load && !(&fetch_cnt_q) ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
      stall_cnt_q <= if_valid && id_stall && !(&stall_cnt_q) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end
  end
  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage.
module tb_fetch_stage;
  logic        clk = 0, rst = 1;
  logic        imem_req, imem_rdy = 0, imem_done = 0, id_stall = 0, redirect = 0;
  logic [15:0] imem_addr, imem_data = '0, redirect_pc = '0;
  logic        if_valid, fetch_halted;
  logic [15:0] if_pc, if_pc_plus2, if_inst;
  int          errors = 0, checks = 0, n_fetch = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif
  always #5 clk = ~clk;
  fetch_stage dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_done(imem_done), .imem_data(imem_data),
    .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc_plus2(if_pc_plus2), .if_inst(if_inst),
`ifdef FETCH_PERF_CNT_EN
    .fetch_halted(fetch_halted), .perf_fetch_cnt(perf_fetch_cnt), .perf_stall_cnt(perf_stall_cnt)
`else
    .fetch_halted(fetch_halted)
`endif
  );
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch_one(input logic [15:0] a, input logic [15:0] d);
    logic [15:0] p2;
    p2 = a + 16'd2;
    imem_rdy = 1; #1;
    chk("req", 32'(imem_req), 1);
    chk("addr", 32'(imem_addr), 32'(a));
    step;
    imem_rdy = 0; imem_done = 1; imem_data = d; #1;
    chk("wait_req", 32'(imem_req), 0);
    chk("wait_valid", 32'(if_valid), 0);
    step;
    imem_done = 0; #1;
    chk("valid", 32'(if_valid), 1);
    chk("if_pc", 32'(if_pc), 32'(a));
    chk("if_pc_plus2", 32'(if_pc_plus2), 32'(p2));
    chk("if_inst", 32'(if_inst), 32'(d));
    n_fetch++;
  endtask
  initial begin
    step; step;
    rst = 0; #1;
    chk("rst_valid", 32'(if_valid), 0);
    chk("rst_inst", 32'(if_inst), 32'h0800);
    chk("rst_pc", 32'(if_pc), 0);
    chk("rst_pc2", 32'(if_pc_plus2), 0);
    chk("rst_halted", 32'(fetch_halted), 0);
    // streaming fetch
    fetch_one(16'h0000, 16'h4000);
    fetch_one(16'h0002, 16'h4100);
    // decode backpressure
    id_stall = 1; imem_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall_req", 32'(imem_req), 0);
      chk("stall_valid", 32'(if_valid), 1);
      chk("stall_inst", 32'(if_inst), 32'h4100);
      chk("stall_pc", 32'(if_pc), 32'h0002);
      step;
    end
    id_stall = 0; imem_rdy = 0;
    fetch_one(16'h0004, 16'h4200);
    // redirect while waiting, late response squashed
    imem_rdy = 1; step;
    imem_rdy = 0; redirect = 1; redirect_pc = 16'h0101; #1;
    chk("redir_req", 32'(imem_req), 0);
    step;
    redirect = 0; imem_done = 1; imem_data = 16'hDEAD; #1;
    chk("drain_req", 32'(imem_req), 0);
    chk("drain_valid", 32'(if_valid), 0);
    step;
    imem_done = 0; #1;
    chk("sq_valid", 32'(if_valid), 0);
    chk("sq_inst", 32'(if_inst), 32'h4200);
    chk("sq_req", 32'(imem_req), 1);
    chk("sq_addr", 32'(imem_addr), 32'h0100);
    // redirect coincident with response
    imem_rdy = 1; step;
    imem_rdy = 0; redirect = 1; redirect_pc = 16'h0200; imem_done = 1; imem_data = 16'h4300;
    step;
    redirect = 0; imem_done = 0; #1;
    chk("same_valid", 32'(if_valid), 0);
    chk("same_inst", 32'(if_inst), 32'h4200);
    chk("same_req", 32'(imem_req), 1);
    chk("same_addr", 32'(imem_addr), 32'h0200);
    // halt and restart
    redirect = 1; redirect_pc = 16'h0010; step;
    redirect = 0;
    fetch_one(16'h0010, 16'h0000);
    chk("halted", 32'(fetch_halted), 1);
    imem_rdy = 1; #1;
    chk("halt_req", 32'(imem_req), 0);
    step; #1;
    chk("halt_req2", 32'(imem_req), 0);
    chk("halt_consumed", 32'(if_valid), 0);
    chk("halted2", 32'(fetch_halted), 1);
    imem_rdy = 0; redirect = 1; redirect_pc = 16'h0020; step;
    redirect = 0; #1;
    chk("unhalt", 32'(fetch_halted), 0);
    chk("unhalt_req", 32'(imem_req), 1);
    chk("unhalt_addr", 32'(imem_addr), 32'h0020);
    // wraparound
    redirect = 1; redirect_pc = 16'hFFFE; step;
    redirect = 0;
    fetch_one(16'hFFFE, 16'h4400);
    chk("wrap_addr", 32'(imem_addr), 0);
    // reset mid-wait, stale response ignored
    imem_rdy = 1; step;
    imem_rdy = 0; rst = 1; step;
    rst = 0; imem_done = 1; imem_data = 16'h0000; #1;
    chk("stale_req", 32'(imem_req), 1);
    chk("stale_addr", 32'(imem_addr), 32'(16'h0000));
    step;
    imem_done = 0; #1;
    chk("stale_valid", 32'(if_valid), 0);
    chk("stale_halt", 32'(fetch_halted), 0);
    chk("stale_inst", 32'(if_inst), 32'h0800);
    n_fetch = 0;
    fetch_one(16'h0000, 16'h4500);
    // redirect under stall invalidates output
    id_stall = 1; redirect = 1; redirect_pc = 16'h0030; #1;
    chk("rs_req", 32'(imem_req), 0);
    step;
    id_stall = 0; redirect = 0; #1;
    chk("rs_valid", 32'(if_valid), 0);
    chk("rs_addr", 32'(imem_addr), 32'h0030);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, 32'(n_fetch));
    chk("perf_stall", perf_stall_cnt, 1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
